// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state types shared by the sequential ALU
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_XOR = 4'b1000,
        OP_SLL = 4'b1001,
        OP_SRL = 4'b1010,
        OP_SRA = 4'b1011,
        OP_MUL = 4'b1100
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

    function automatic logic is_reserved(input logic [3:0] op);
        return !(op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT,
                            OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_MUL});
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one multiplier bit per cycle, low WIDTH bits of a*b
//   clk, reset : clock, asynchronous active-high reset
//   start      : begin a multiply with a/b (ignored while busy)
//   a, b       : operands
//   done       : product valid; stays high until the next start
//   product    : low WIDTH bits of a*b
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_acc, r_mcand, r_mplier;
    logic [SHW-1:0]   r_cnt;
    logic             r_busy, r_done;

    // Bit 0 is folded into the start edge so WIDTH edges in total cover all bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (start && !r_busy) begin
            r_acc    <= b[0] ? a : '0;
            r_mcand  <= a << 1;
            r_mplier <= b >> 1;
            r_cnt    <= SHW'(1);
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_busy) begin
            if (r_mplier[0])
                r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == SHW'(WIDTH - 1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign done    = r_done;
    assign product = r_acc;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags and an iterative multiply
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready   : operation handshake (a, b, alucontrol sampled on transfer)
//   out_valid/out_ready : result handshake; result and flags held until consumed
//   result              : registered result
//   zero/negative       : derived from the registered result
//   carry/overflow      : ADD/SUB/SLT only, 0 otherwise
//   illegal             : accepted opcode was reserved
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alucontrol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             illegal
);
    localparam int SHW = $clog2(WIDTH);

    alu_state_e       r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_zero, r_carry, r_overflow, r_negative, r_illegal, r_out_valid;

    logic [WIDTH-1:0] w_binv, w_res, w_prod, w_ld_res;
    logic [WIDTH:0]   w_sum;
    logic [SHW-1:0]   w_sh;
    logic             w_ovf, w_arith, w_slot_free, w_accept, w_is_mul, w_mul_done;
    logic             w_load_single, w_load_mul, w_load;

    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = !reset && (r_state == IDLE) && w_slot_free;
    assign w_accept    = in_valid && in_ready;
    assign w_is_mul    = alucontrol == OP_MUL;

    // SUB and SLT share the inverted-b adder path, keyed on opcode bit 2.
    assign w_binv  = alucontrol[2] ? ~b : b;
    assign w_sum   = {1'b0, a} + {1'b0, w_binv} + {{WIDTH{1'b0}}, alucontrol[2]};
    assign w_ovf   = (a[WIDTH-1] == w_binv[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    assign w_arith = alucontrol inside {OP_ADD, OP_SUB, OP_SLT};
    assign w_sh    = b[SHW-1:0];

    always_comb begin
        w_res = '0;
        case (alu_op_e'(alucontrol))
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_ADD,
            OP_SUB:  w_res = w_sum[WIDTH-1:0];
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
            OP_XOR:  w_res = a ^ b;
            OP_SLL:  w_res = a << w_sh;
            OP_SRL:  w_res = a >> w_sh;
            OP_SRA:  w_res = $signed(a) >>> w_sh;
            default: w_res = '0;
        endcase
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (w_accept && w_is_mul),
        .a       (a),
        .b       (b),
        .done    (w_mul_done),
        .product (w_prod)
    );

    // A finished product waits in MUL until the output slot can take it.
    assign w_load_single = w_accept && !w_is_mul;
    assign w_load_mul    = (r_state == MUL) && w_mul_done && w_slot_free;
    assign w_load        = w_load_single || w_load_mul;
    assign w_ld_res      = w_load_mul ? w_prod : w_res;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_negative  <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_result   <= w_ld_res;
                r_zero     <= w_ld_res == '0;
                r_negative <= w_ld_res[WIDTH-1];
                r_carry    <= w_load_single && w_arith && w_sum[WIDTH];
                r_overflow <= w_load_single && w_arith && w_ovf;
                r_illegal  <= w_load_single && is_reserved(alucontrol);
            end
            r_out_valid <= w_load || (r_out_valid && !out_ready);
            if (r_state == IDLE && w_accept && w_is_mul)
                r_state <= MUL;
            else if (w_load_mul)
                r_state <= IDLE;
        end
    end

    assign result    = r_result;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign negative  = r_negative;
    assign illegal   = r_illegal;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table plus multi-cycle sequences for alu_seq
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [3:0] alucontrol = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic       zero, carry, overflow, negative, illegal;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .alucontrol (alucontrol),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .carry      (carry),
        .overflow   (overflow),
        .negative   (negative),
        .illegal    (illegal)
    );

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c, v, n, z, ill;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // {result, carry, overflow, negative, zero, illegal, out_valid, in_ready}
    function automatic logic [31:0] outs();
        return {17'd0, result, carry, overflow, negative, zero, illegal, out_valid, in_ready};
    endfunction

    function automatic logic [31:0] exp_outs(input logic [7:0] r, input logic c, v, n, z, ill, ov, ir);
        return {17'd0, r, c, v, n, z, ill, ov, ir};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           op       a      b      res    c     v     n     z     ill
        vecs[0]  = '{4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4'b0110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{4'b0111, 8'h80, 8'h01, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{4'b1011, 8'h90, 8'h0B, 8'hF2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{4'b1111, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'b0001, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{4'b1000, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'b1001, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{4'b1010, 8'h80, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'b0010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{4'b0110, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{4'b0111, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{4'b0011, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        tick();
        tick();
        check("reset_outputs", outs(), exp_outs(8'h00, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        #1;
        check("ready_after_reset", outs(), exp_outs(8'h00, 0, 0, 0, 0, 0, 0, 1));

        // Back-to-back single-cycle ops with in_valid held: one result per cycle.
        for (int i = 0; i < 14; i++) begin
            a = vecs[i].a;
            b = vecs[i].b;
            alucontrol = vecs[i].op;
            in_valid = 1'b1;
            tick();
            check($sformatf("vec%0d_op%b", i, vecs[i].op), outs(),
                  exp_outs(vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].n, vecs[i].z, vecs[i].ill, 1, 1));
        end
        in_valid = 1'b0;
        tick();
        check("drain_after_table", {31'd0, out_valid}, 32'd0);

        // MUL 0x0D * 0x0B = 0x8F, out_valid exactly 8 edges after accept.
        a = 8'h0D; b = 8'h0B; alucontrol = 4'b1100; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = 8'hFF; b = 8'hFF; alucontrol = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("mul_busy%0d", i), {30'd0, in_ready, out_valid}, 32'd0);
            tick();
        end
        check("mul_result", outs(), exp_outs(8'h8F, 0, 0, 1, 0, 0, 1, 1));
        out_ready = 1'b0;
        tick();
        tick();
        check("mul_result_held", outs(), exp_outs(8'h8F, 0, 0, 1, 0, 0, 1, 0));
        out_ready = 1'b1;
        tick();
        check("mul_consumed", {31'd0, out_valid}, 32'd0);

        // Back-pressure: ADD result held, OR waits, then OR accepted as ADD is consumed.
        out_ready = 1'b0;
        a = 8'h03; b = 8'h04; alucontrol = 4'b0010; in_valid = 1'b1;
        tick();
        check("bp_add", outs(), exp_outs(8'h07, 0, 0, 0, 0, 0, 1, 0));
        a = 8'h50; b = 8'h05; alucontrol = 4'b0001;
        tick();
        tick();
        tick();
        check("bp_hold", outs(), exp_outs(8'h07, 0, 0, 0, 0, 0, 1, 0));
        out_ready = 1'b1;
        #1;
        check("bp_ready_returns", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_or", outs(), exp_outs(8'h55, 0, 0, 0, 0, 0, 1, 1));
        tick();

        // Reset three cycles into a MUL: outputs clear at once, no late product.
        a = 8'h0D; b = 8'h0B; alucontrol = 4'b1100; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("reset_mid_mul", outs(), exp_outs(8'h00, 0, 0, 0, 0, 0, 0, 0));
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("mul_aborted%0d", i), {30'd0, in_ready, out_valid}, 32'd2);
        end
        a = 8'h01; b = 8'h01; alucontrol = 4'b0010; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("add_after_reset", outs(), exp_outs(8'h02, 0, 0, 0, 0, 0, 1, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
